// File: rtl/aq_jpeg_hdr_pkg.sv
// aq_jpeg_hdr_pkg: marker codes, table map, FSM states and byte helpers for the JPEG header writer
package aq_jpeg_hdr_pkg;
  localparam logic [7:0] M_SOI = 8'hD8, M_DQT = 8'hDB, M_SOF0 = 8'hC0;
  localparam logic [7:0] M_DHT = 8'hC4, M_DRI = 8'hDD, M_SOS = 8'hDA;
  localparam logic [9:0] QY_BASE = 10'h000, QC_BASE = 10'h040;
  localparam logic [9:0] DC0_BASE = 10'h080, AC0_BASE = 10'h0A0, DC1_BASE = 10'h160, AC1_BASE = 10'h180;
  localparam logic [7:0] TCTH_DC0 = 8'h00, TCTH_AC0 = 8'h10, TCTH_DC1 = 8'h01, TCTH_AC1 = 8'h11;
  typedef enum logic [3:0] {
    S_IDLE, S_SOI, S_DQT, S_SOF, S_DHT_SUM, S_DHT_HDR, S_DHT_BITS, S_DHT_VAL,
`ifdef AQ_JPEG_HDR_DRI_EN
    S_DRI,
`endif
    S_SOS, S_DONE
  } state_e;
  function automatic logic [9:0] dht_base(input logic [1:0] seg);
    return seg == 2'd0 ? DC0_BASE : seg == 2'd1 ? AC0_BASE : seg == 2'd2 ? DC1_BASE : AC1_BASE;
  endfunction
  function automatic logic [7:0] dht_tcth(input logic [1:0] seg);
    return seg == 2'd0 ? TCTH_DC0 : seg == 2'd1 ? TCTH_AC0 : seg == 2'd2 ? TCTH_DC1 : TCTH_AC1;
  endfunction
  // Fixed segment bytes are packed MSB-first into 19-byte vectors; pick byte i.
  function automatic logic [7:0] pick(input logic [151:0] v, input logic [4:0] i);
    logic [151:0] s;
    s = v << (8 * i);
    return s[151:144];
  endfunction
endpackage

// File: rtl/aq_jpeg_hdr_byte_out.sv
// aq_jpeg_hdr_byte_out: one-entry output register holding data/last stable until accepted
module aq_jpeg_hdr_byte_out (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  input  logic       out_ready_i
);
  logic       vld_q, last_q;
  logic [7:0] data_q;
  assign in_ready_o  = !vld_q || out_ready_i;
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (in_ready_o) begin
      vld_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
        last_q <= in_last_i;
      end
    end
  end
endmodule

// File: rtl/aq_jpeg_hdr_gen.sv
// aq_jpeg_hdr_gen: baseline JPEG header byte-stream writer (SOI/DQT/SOF0/DHT/[DRI]/SOS).
// Define AQ_JPEG_HDR_DRI_EN to add dri_interval and the optional DRI segment.
module aq_jpeg_hdr_gen
  import aq_jpeg_hdr_pkg::*;
#(
  parameter int TBL_AW   = 10,
  parameter int COMP_ID0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              gray,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic [1:0]        samp_h,
  input  logic [1:0]        samp_v,
`ifdef AQ_JPEG_HDR_DRI_EN
  input  logic [15:0]       dri_interval,
`endif
  output logic              busy,
  output logic              done,
  output logic              tbl_rd,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [7:0]        tbl_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);
  localparam logic [7:0] ID0 = 8'(COMP_ID0);
  state_e       st_q, st_d, post_dht, nxt_tab;
  logic [11:0]  idx_q, sum_q, last_idx, taddr;
  logic [1:0]   seg_q, sh_q, sv_q;
  logic [15:0]  width_q, height_q, dri_q;
  logic [7:0]   tdat_q, byte_d, nc;
  logic         vld_q, hv_q, busy_q, done_q, gray_q;
  logic         is_tbl, emit, push, adv, fetch, at_last, bo_rdy;
  logic [151:0] v, sof_v, sos_v, dqt_v, dht_v, dri_v;
`ifdef AQ_JPEG_HDR_DRI_EN
  assign post_dht = dri_q != '0 ? S_DRI : S_SOS;
`else
  assign post_dht = S_SOS;
`endif
  assign nxt_tab = (gray_q ? seg_q == 2'd1 : seg_q == 2'd3) ? post_dht : S_DHT_SUM;
  assign nc    = gray_q ? 8'd1 : 8'd3;
  assign sof_v = {8'hFF, M_SOF0, 8'h00, gray_q ? 8'd11 : 8'd17, 8'h08, height_q, width_q, nc,
                  ID0, {2'b00, sh_q, 2'b00, sv_q}, 8'h00, ID0 + 8'd1, 8'h11, 8'h01, ID0 + 8'd2, 8'h11, 8'h01};
  assign sos_v = gray_q ? {8'hFF, M_SOS, 8'h00, 8'h08, 8'h01, ID0, 8'h00, 8'h00, 8'h3F, 8'h00, 72'h0}
                        : {8'hFF, M_SOS, 8'h00, 8'h0C, 8'h03, ID0, 8'h00, ID0 + 8'd1, 8'h11,
                           ID0 + 8'd2, 8'h11, 8'h00, 8'h3F, 8'h00, 40'h0};
  assign dqt_v = {8'hFF, M_DQT, 8'h00, 8'h43, 7'h0, seg_q[0], 112'h0};
  assign dht_v = {8'hFF, M_DHT, 16'(sum_q) + 16'd19, dht_tcth(seg_q), 112'h0};
  assign dri_v = {8'hFF, M_DRI, 8'h00, 8'h04, dri_q, 104'h0};
  always_comb begin
    v = '0;
    is_tbl = 1'b0;
    emit = 1'b1;
    last_idx = '0;
    taddr = '0;
    st_d = st_q;
    case (st_q)
      S_SOI: begin v = {8'hFF, M_SOI, 136'h0}; last_idx = 12'd1; st_d = S_DQT; end
      S_DQT: begin
        v = dqt_v;
        is_tbl = idx_q >= 12'd5;
        taddr = 12'(seg_q[0] ? QC_BASE : QY_BASE) + idx_q - 12'd5;
        last_idx = 12'd68;
        st_d = (seg_q == 2'd0 && !gray_q) ? S_DQT : S_SOF;
      end
      S_SOF: begin v = sof_v; last_idx = gray_q ? 12'd12 : 12'd18; st_d = S_DHT_SUM; end
      // Counts are read once to size L, then re-read for emission.
      S_DHT_SUM: begin
        emit = 1'b0;
        is_tbl = 1'b1;
        taddr = 12'(dht_base(seg_q)) + idx_q;
        last_idx = 12'd15;
        st_d = S_DHT_HDR;
      end
      S_DHT_HDR: begin v = dht_v; last_idx = 12'd4; st_d = S_DHT_BITS; end
      S_DHT_BITS: begin
        is_tbl = 1'b1;
        taddr = 12'(dht_base(seg_q)) + idx_q;
        last_idx = 12'd15;
        st_d = sum_q == '0 ? nxt_tab : S_DHT_VAL;
      end
      S_DHT_VAL: begin
        is_tbl = 1'b1;
        taddr = 12'(dht_base(seg_q)) + 12'd16 + idx_q;
        last_idx = sum_q - 12'd1;
        st_d = nxt_tab;
      end
`ifdef AQ_JPEG_HDR_DRI_EN
      S_DRI: begin v = dri_v; last_idx = 12'd5; st_d = S_SOS; end
`endif
      S_SOS: begin v = sos_v; last_idx = gray_q ? 12'd9 : 12'd13; st_d = S_DONE; end
      default: emit = 1'b0;
    endcase
  end
  // A table byte is either arriving from RAM this cycle or parked in tdat_q after a stall.
  assign byte_d   = is_tbl ? (hv_q ? tdat_q : tbl_data) : pick(v, idx_q[4:0]);
  assign at_last  = idx_q == last_idx;
  assign push     = emit && (!is_tbl || vld_q || hv_q) && bo_rdy;
  assign adv      = push || (st_q == S_DHT_SUM && (vld_q || hv_q));
  assign fetch    = is_tbl && !vld_q && !hv_q;
  assign tbl_rd   = fetch;
  assign tbl_addr = fetch ? TBL_AW'(taddr) : '0;
  assign busy     = busy_q;
  assign done     = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      idx_q <= '0;
      seg_q <= '0;
      sum_q <= '0;
      vld_q <= 1'b0;
      hv_q <= 1'b0;
      tdat_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      gray_q <= 1'b0;
      width_q <= '0;
      height_q <= '0;
      sh_q <= '0;
      sv_q <= '0;
      dri_q <= '0;
    end else begin
      done_q <= 1'b0;
      vld_q <= fetch;
      if (adv) hv_q <= 1'b0;
      else if (vld_q) begin
        hv_q <= 1'b1;
        tdat_q <= tbl_data;
      end
      if (st_q == S_IDLE) begin
        if (start && !done_q) begin
          st_q <= S_SOI;
          busy_q <= 1'b1;
          idx_q <= '0;
          seg_q <= '0;
          gray_q <= gray;
          width_q <= width;
          height_q <= height;
          sh_q <= samp_h;
          sv_q <= samp_v;
`ifdef AQ_JPEG_HDR_DRI_EN
          dri_q <= dri_interval;
`endif
        end
      end else if (st_q == S_DONE) begin
        if (out_valid && out_ready) begin
          st_q <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (adv) begin
        idx_q <= at_last ? '0 : idx_q + 12'd1;
        if (st_q == S_DHT_SUM) sum_q <= (idx_q == '0 ? '0 : sum_q) + 12'(byte_d);
        if (at_last) begin
          st_q <= st_d;
          seg_q <= st_q == S_SOF ? 2'd0 : (st_q == S_DQT || st_d == S_DHT_SUM) ? seg_q + 2'd1 : seg_q;
        end
      end
    end
  end
  aq_jpeg_hdr_byte_out u_out (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (push),
    .in_data_i  (byte_d),
    .in_last_i  (st_q == S_SOS && at_last),
    .in_ready_o (bo_rdy),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_ready_i(out_ready)
  );
endmodule
